// File: rtl/pe_multistep.sv
// pe_multistep: multi-beat dot-product processing element.
//
// Each en beat forms sum_k in[k]*weight[k] (unsigned activation times signed
// weight). The first beat of a group adds the bias. Beats are accumulated
// across a group of step+1 beats into a saturating accumulator. The group
// result is then rounded, right-shifted, saturated, optionally ReLU-clamped,
// and presented on out with a one-cycle out_en pulse.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   in       N_CELL unsigned activations, cell k at [k*CELL_BIT +: CELL_BIT]
//   weight   N_CELL two's-complement weights, same packing
//   bias     signed bias, added on the first beat of a group only
//   en       beat valid
//   step     group length minus one (sampled on the first beat)
//   shift    output right-shift amount (sampled on the first beat)
//   relu_en  clamp negative results to zero (sampled on the first beat)
//   clear    synchronous group abort
//   out      signed result, held between pulses
//   out_en   one-cycle result-valid pulse
module pe_multistep #(
    parameter int CELL_BIT  = 8,
    parameter int N_CELL    = 9,
    parameter int BIAS_BIT  = 16,
    parameter int ACC_BIT   = 24,
    parameter int OUT_BIT   = 8,
    parameter int STEP_BIT  = 3,
    parameter int SHIFT_BIT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CELL_BIT*N_CELL-1:0] in,
    input  logic [CELL_BIT*N_CELL-1:0] weight,
    input  logic [BIAS_BIT-1:0]        bias,
    input  logic                       en,
    input  logic [STEP_BIT-1:0]        step,
    input  logic [SHIFT_BIT-1:0]       shift,
    input  logic                       relu_en,
    input  logic                       clear,
    output logic [OUT_BIT-1:0]         out,
    output logic                       out_en
);

    localparam int PROD_W = 2*CELL_BIT + 1;
    localparam int DOT_W  = PROD_W + $clog2(N_CELL);
    localparam int BEAT_W = ((DOT_W > BIAS_BIT) ? DOT_W : BIAS_BIT) + 1;
    localparam int SUM_W  = ((BEAT_W > ACC_BIT) ? BEAT_W : ACC_BIT) + 1;
    localparam int RND_W  = ACC_BIT + 1;

    function automatic logic signed [ACC_BIT-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        if (!v[SUM_W-1] && (|v[SUM_W-2:ACC_BIT-1]))
            sat_acc = {1'b0, {(ACC_BIT-1){1'b1}}};
        else if (v[SUM_W-1] && !(&v[SUM_W-2:ACC_BIT-1]))
            sat_acc = {1'b1, {(ACC_BIT-1){1'b0}}};
        else
            sat_acc = v[ACC_BIT-1:0];
    endfunction

    function automatic logic signed [OUT_BIT-1:0] sat_out(input logic signed [RND_W-1:0] v);
        if (!v[RND_W-1] && (|v[RND_W-2:OUT_BIT-1]))
            sat_out = {1'b0, {(OUT_BIT-1){1'b1}}};
        else if (v[RND_W-1] && !(&v[RND_W-2:OUT_BIT-1]))
            sat_out = {1'b1, {(OUT_BIT-1){1'b0}}};
        else
            sat_out = v[OUT_BIT-1:0];
    endfunction

    // Round half up, then arithmetic shift (floor); one guard bit absorbs the rounding add.
    function automatic logic signed [RND_W-1:0] round_shift(input logic signed [ACC_BIT-1:0] a,
                                                             input logic [SHIFT_BIT-1:0] sh);
        logic signed [RND_W-1:0] ext;
        ext = RND_W'(a);
        if (sh != '0)
            ext = ext + (RND_W'(1) <<< (sh - 1'b1));
        return ext >>> sh;
    endfunction

    function automatic logic [OUT_BIT-1:0] post_proc(input logic signed [ACC_BIT-1:0] a,
                                                     input logic [SHIFT_BIT-1:0] sh,
                                                     input logic relu);
        logic signed [OUT_BIT-1:0] r;
        r = sat_out(round_shift(a, sh));
        if (relu && r[OUT_BIT-1])
            r = '0;
        return r;
    endfunction

    // Group control and captured configuration
    logic [STEP_BIT-1:0]  cnt_q, cnt_d, step_q, step_d, step_eff;
    logic [SHIFT_BIT-1:0] shift_q, shift_d;
    logic                 relu_q, relu_d;
    logic                 first_beat, last_beat, beat_go;

    // Stage 1 registers
    logic                     vld_p1_q, vld_p1_d, first_p1_q, first_p1_d, last_p1_q, last_p1_d;
    logic                     relu_p1_q, relu_p1_d;
    logic [SHIFT_BIT-1:0]     shift_p1_q, shift_p1_d;
    logic signed [BEAT_W-1:0] beat_p1_q, beat_p1_d;

    // Stage 2 registers
    logic signed [ACC_BIT-1:0] acc_p2_q, acc_p2_d;
    logic                      pend_p2_q, pend_p2_d, relu_p2_q, relu_p2_d;
    logic [SHIFT_BIT-1:0]      shift_p2_q, shift_p2_d;

    // Output registers
    logic [OUT_BIT-1:0] out_q, out_d;
    logic               out_en_q, out_en_d;

    logic signed [PROD_W-1:0] prod [N_CELL];
    logic signed [BEAT_W-1:0] beat_val;

    // Stage 0: beat formation and group counter
    always_comb begin
        first_beat = (cnt_q == '0);
        step_eff   = first_beat ? step : step_q;
        last_beat  = (cnt_q == step_eff);
        beat_go    = en && !clear;

        prod     = '{default: '0};
        beat_val = '0;
        for (int k = 0; k < N_CELL; k++) begin
            prod[k]  = PROD_W'($signed({1'b0, in[k*CELL_BIT +: CELL_BIT]}))
                     * PROD_W'($signed(weight[k*CELL_BIT +: CELL_BIT]));
            beat_val = beat_val + BEAT_W'(prod[k]);
        end
        if (first_beat)
            beat_val = beat_val + BEAT_W'($signed(bias));

        cnt_d   = cnt_q;
        step_d  = step_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last_beat ? '0 : cnt_q + 1'b1;
            if (first_beat) begin
                step_d  = step;
                shift_d = shift;
                relu_d  = relu_en;
            end
        end

        vld_p1_d   = beat_go;
        beat_p1_d  = beat_val;
        first_p1_d = first_beat;
        last_p1_d  = last_beat;
        shift_p1_d = first_beat ? shift : shift_q;
        relu_p1_d  = first_beat ? relu_en : relu_q;
    end

    // Stage 1 -> 2: accumulate; clear drops the stage-1 beat and zeroes the sum
    always_comb begin
        acc_p2_d   = acc_p2_q;
        pend_p2_d  = 1'b0;
        shift_p2_d = shift_p2_q;
        relu_p2_d  = relu_p2_q;
        if (clear) begin
            acc_p2_d = '0;
        end else if (vld_p1_q) begin
            acc_p2_d   = first_p1_q ? sat_acc(SUM_W'(beat_p1_q))
                                    : sat_acc(SUM_W'(acc_p2_q) + SUM_W'(beat_p1_q));
            pend_p2_d  = last_p1_q;
            shift_p2_d = shift_p1_q;
            relu_p2_d  = relu_p1_q;
        end
    end

    // Stage 2 -> output: a finished sum in stage 2 is emitted even under clear
    always_comb begin
        out_en_d = pend_p2_q;
        out_d    = pend_p2_q ? post_proc(acc_p2_q, shift_p2_q, relu_p2_q) : out_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            step_q     <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            vld_p1_q   <= 1'b0;
            first_p1_q <= 1'b0;
            last_p1_q  <= 1'b0;
            shift_p1_q <= '0;
            relu_p1_q  <= 1'b0;
            acc_p2_q   <= '0;
            pend_p2_q  <= 1'b0;
            shift_p2_q <= '0;
            relu_p2_q  <= 1'b0;
            out_q      <= '0;
            out_en_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
            vld_p1_q   <= vld_p1_d;
            first_p1_q <= first_p1_d;
            last_p1_q  <= last_p1_d;
            shift_p1_q <= shift_p1_d;
            relu_p1_q  <= relu_p1_d;
            acc_p2_q   <= acc_p2_d;
            pend_p2_q  <= pend_p2_d;
            shift_p2_q <= shift_p2_d;
            relu_p2_q  <= relu_p2_d;
            out_q      <= out_d;
            out_en_q   <= out_en_d;
        end
    end

    // Beat data is qualified by vld_p1_q, so it needs no reset
    always_ff @(posedge clk) begin
        beat_p1_q <= beat_p1_d;
    end

    assign out    = out_q;
    assign out_en = out_en_q;

endmodule

// File: tb/tb_pe_multistep.sv
module tb_pe_multistep;

    localparam int CELL_BIT  = 8;
    localparam int N_CELL    = 9;
    localparam int BIAS_BIT  = 16;
    localparam int ACC_BIT   = 20;   // narrowed so accumulator saturation is reachable
    localparam int OUT_BIT   = 8;
    localparam int STEP_BIT  = 3;
    localparam int SHIFT_BIT = 4;
    localparam int MAXC      = 8192;
    localparam longint AMAX  = (longint'(1) <<< (ACC_BIT-1)) - 1;
    localparam longint AMIN  = -(longint'(1) <<< (ACC_BIT-1));

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic [CELL_BIT*N_CELL-1:0] in_i = '0;
    logic [CELL_BIT*N_CELL-1:0] w_i = '0;
    logic [BIAS_BIT-1:0]        bias_i = '0;
    logic                       en_i = 1'b0;
    logic [STEP_BIT-1:0]        step_i = '0;
    logic [SHIFT_BIT-1:0]       shift_i = '0;
    logic                       relu_i = 1'b0;
    logic                       clear_i = 1'b0;
    logic [OUT_BIT-1:0]         out_o;
    logic                       out_en_o;

    always #5 clk = ~clk;

    pe_multistep #(
        .CELL_BIT(CELL_BIT), .N_CELL(N_CELL), .BIAS_BIT(BIAS_BIT), .ACC_BIT(ACC_BIT),
        .OUT_BIT(OUT_BIT), .STEP_BIT(STEP_BIT), .SHIFT_BIT(SHIFT_BIT)
    ) dut (
        .clk(clk), .reset(reset), .in(in_i), .weight(w_i), .bias(bias_i), .en(en_i),
        .step(step_i), .shift(shift_i), .relu_en(relu_i), .clear(clear_i),
        .out(out_o), .out_en(out_en_o)
    );

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    bit     exp_en [MAXC];
    int     exp_val [MAXC];
    int     m_cnt = 0, m_step = 0, m_shift = 0, m_out = 0;
    bit     m_relu = 0;
    longint m_sum = 0;
    int     cur_a [N_CELL];
    int     cur_w [N_CELL];
    int     cur_bias = 0;
    int     got_q [$];

    typedef struct {
        int a; int w; int bias; int shift; bit relu; int exp;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint dot();
        longint s = 0;
        for (int k = 0; k < N_CELL; k++) s += longint'(cur_a[k]) * longint'(cur_w[k]);
        return s;
    endfunction

    function automatic int post(input longint s, input int sh, input bit relu);
        longint v = s;
        if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
        v = v >>> sh;
        v = clamp(v, -128, 127);
        if (relu && v < 0) v = 0;
        return int'(v);
    endfunction

    task automatic drive();
        for (int k = 0; k < N_CELL; k++) begin
            in_i[k*CELL_BIT +: CELL_BIT] = cur_a[k][7:0];
            w_i[k*CELL_BIT +: CELL_BIT]  = cur_w[k][7:0];
        end
        bias_i = cur_bias[15:0];
    endtask

    // One clock: update the group-level model from the driven inputs, then compare.
    task automatic tick();
        int e;
        longint d;
        drive();
        e = cyc + 1;
        if (clear_i) begin
            m_cnt = 0;
            m_sum = 0;
            exp_en[e+1] = 0;               // a last beat still in flight is aborted
        end else if (en_i) begin
            d = dot();
            if (m_cnt == 0) begin
                m_step  = int'(step_i);
                m_shift = int'(shift_i);
                m_relu  = relu_i;
                m_sum   = clamp(d + cur_bias, AMIN, AMAX);
            end else begin
                m_sum = clamp(m_sum + d, AMIN, AMAX);
            end
            if (m_cnt == m_step) begin
                exp_en[e+2]  = 1;
                exp_val[e+2] = post(m_sum, m_shift, m_relu);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        cyc = e;
        if (exp_en[cyc]) m_out = exp_val[cyc];
        check("out_en", int'(out_en_o), int'(exp_en[cyc]));
        check("out", int'($signed(out_o)), m_out);
        if (out_en_o) got_q.push_back(int'($signed(out_o)));
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        en_i    = 1'b0;
        clear_i = 1'b0;
        #2;
        check("rst_out", int'($signed(out_o)), 0);
        check("rst_out_en", int'(out_en_o), 0);
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b1;
        m_cnt = 0;
        m_sum = 0;
        m_out = 0;
        for (int i = cyc; i < cyc + 4; i++) exp_en[i] = 0;
    endtask

    task automatic set_dot(input int v);
        for (int k = 0; k < N_CELL; k++) begin
            cur_a[k] = 0;
            cur_w[k] = 0;
        end
        cur_a[0] = 1;
        cur_w[0] = v;
    endtask

    task automatic set_all(input int a, input int w);
        for (int k = 0; k < N_CELL; k++) begin
            cur_a[k] = a;
            cur_w[k] = w;
        end
    endtask

    task automatic beat();
        en_i = 1'b1;
        tick();
        en_i = 1'b0;
    endtask

    task automatic idle(input int n);
        en_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg(input int st, input int sh, input bit rl, input int b);
        step_i   = st[STEP_BIT-1:0];
        shift_i  = sh[SHIFT_BIT-1:0];
        relu_i   = rl;
        cur_bias = b;
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            exp_en[i]  = 0;
            exp_val[i] = 0;
        end
        set_all(0, 0);
        #1;
        do_reset();

        // Single-beat groups with hand-computed results
        tbl[0] = '{a:1,   w:2,    bias:0,    shift:0, relu:0, exp:18};
        tbl[1] = '{a:255, w:127,  bias:0,    shift:0, relu:0, exp:127};
        tbl[2] = '{a:255, w:-128, bias:0,    shift:0, relu:0, exp:-128};
        tbl[3] = '{a:255, w:-128, bias:0,    shift:0, relu:1, exp:0};
        tbl[4] = '{a:10,  w:1,    bias:0,    shift:0, relu:0, exp:90};
        tbl[5] = '{a:3,   w:-3,   bias:-5,   shift:1, relu:0, exp:-43};
        tbl[6] = '{a:0,   w:0,    bias:100,  shift:0, relu:0, exp:100};
        tbl[7] = '{a:4,   w:5,    bias:-300, shift:2, relu:0, exp:-30};
        tbl[8] = '{a:7,   w:-1,   bias:0,    shift:0, relu:1, exp:0};
        tbl[9] = '{a:2,   w:3,    bias:0,    shift:3, relu:0, exp:7};
        for (int i = 0; i < 10; i++) begin
            set_all(tbl[i].a, tbl[i].w);
            cfg(0, tbl[i].shift, tbl[i].relu, tbl[i].bias);
            beat();
            tick();
            check("tbl_early", int'(out_en_o), 0);
            tick();
            check("tbl_out_en", int'(out_en_o), 1);
            check("tbl_out", int'($signed(out_o)), tbl[i].exp);
            tick();
            check("tbl_pulse_end", int'(out_en_o), 0);
            check("tbl_hold", int'($signed(out_o)), tbl[i].exp);
        end

        // Three-beat group with gaps; mid-group config changes are ignored
        got_q.delete();
        cfg(2, 0, 0, 5); set_dot(10); beat(); idle(2);
        cfg(0, 3, 1, 0); beat(); idle(1); beat();
        check("grp_none_early", got_q.size(), 0);
        idle(4);
        check("grp_count", got_q.size(), 1);
        if (got_q.size() > 0) check("grp_sum35", got_q[0], 35);

        got_q.delete();
        cfg(2, 2, 0, 5); set_dot(10); beat(); beat(); beat(); idle(4);
        if (got_q.size() == 1) check("grp_shift_pos", got_q[0], 9);
        else check("grp_shift_pos_count", got_q.size(), 1);
        got_q.delete();
        cfg(2, 2, 0, -5); set_dot(-10); beat(); beat(); beat(); idle(4);
        if (got_q.size() == 1) check("grp_shift_neg", got_q[0], -9);
        else check("grp_shift_neg_count", got_q.size(), 1);

        // Continuous single-beat groups, no bubbles
        got_q.delete();
        cfg(0, 0, 0, 0);
        en_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_dot((i % 2 == 0) ? 3 : -4);
            tick();
        end
        idle(3);
        check("b2b_count", got_q.size(), 8);
        for (int i = 0; i < got_q.size() && i < 8; i++)
            check("b2b_val", got_q[i], (i % 2 == 0) ? 3 : -4);

        // Accumulator saturation observed through a wide shift
        got_q.delete();
        cfg(1, 15, 0, 0); set_all(255, 127); beat(); beat(); idle(3);
        cfg(1, 15, 0, 0); set_all(255, -128); beat(); beat(); idle(3);
        check("acc_sat_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("acc_sat_pos", got_q[0], 16);
            check("acc_sat_neg", got_q[1], -16);
        end

        // Clear and reset abort groups; the following group is clean
        got_q.delete();
        cfg(3, 0, 0, 0); set_dot(10); beat();
        clear_i = 1'b1; en_i = 1'b1; tick(); clear_i = 1'b0; en_i = 1'b0;
        idle(2);
        beat(); beat(); beat(); beat(); idle(3);
        cfg(3, 0, 0, 0); set_dot(20); beat(); beat();
        do_reset();
        idle(3);
        cfg(1, 0, 0, 1); set_dot(5); beat(); set_dot(6); beat(); idle(4);
        check("abort_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("abort_next40", got_q[0], 40);
            check("abort_after_rst12", got_q[1], 12);
        end

        // Clear with a finished sum in stage 2 keeps it; one cycle earlier it is lost
        got_q.delete();
        cfg(0, 0, 0, 0); set_dot(7); beat(); idle(1);
        clear_i = 1'b1; tick(); clear_i = 1'b0; idle(2);
        set_dot(9); beat();
        clear_i = 1'b1; tick(); clear_i = 1'b0; idle(3);
        check("clr_keep_count", got_q.size(), 1);
        if (got_q.size() == 1) check("clr_keep_val", got_q[0], 7);

        // Randomized traffic against the model
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                set_all(255, ($urandom_range(0, 1) == 0) ? 127 : -128);
            end else begin
                for (int k = 0; k < N_CELL; k++) begin
                    cur_a[k] = int'($urandom_range(0, 255));
                    cur_w[k] = int'($urandom_range(0, 255)) - 128;
                end
            end
            cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                ($urandom_range(0, 4) == 0), int'($urandom_range(0, 65535)) - 32768);
            en_i    = ($urandom_range(0, 9) < 7);
            clear_i = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            else tick();
        end
        clear_i = 1'b0;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_multistep.md
PE_MULTISTEP -- requirements
Module: pe_multistep

Interface
REQ-001 The block SHALL provide these parameters (name, default, meaning):
- CELL_BIT, 8, operand width per cell
- N_CELL, 9, cells per dot product
- BIAS_BIT, 16, signed bias width
- ACC_BIT, 24, signed accumulator width
- OUT_BIT, 8, signed output width
- STEP_BIT, 3, group-length field width
- SHIFT_BIT, 4, right-shift field width
REQ-002 The block SHALL provide these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on rising edge
- reset, in, 1, asynchronous active-low reset
- in, in, CELL_BIT*N_CELL, unsigned activations, cell k at bits [k*CELL_BIT +: CELL_BIT]
- weight, in, CELL_BIT*N_CELL, two's-complement weights, same packing
- bias, in, BIAS_BIT, signed bias
- en, in, 1, beat valid
- step, in, STEP_BIT, group length minus one
- shift, in, SHIFT_BIT, output right-shift amount
- relu_en, in, 1, clamp negative results to zero
- clear, in, 1, synchronous group abort
- out, out, OUT_BIT, signed result
- out_en, out, 1, one-cycle result-valid pulse

Function
REQ-003 Each en=1 cycle is a beat; beat value = sum over k of in[k]*weight[k] (exact signed, no intermediate truncation) plus sign-extended bias only when the beat is the first beat of a group.
REQ-004 Stage 1 SHALL register the beat value and a first/last tag; stage 2 SHALL load (first) or add (otherwise) it into the accumulator.
REQ-005 The accumulator SHALL saturate at the signed ACC_BIT bounds instead of wrapping.
REQ-006 A beat counter SHALL count 0..step; the beat at count==step is last, the counter then returns to 0; step=0 makes every beat both first and last.
REQ-007 step, shift and relu_en SHALL be captured on the first beat and held for the whole group; changes mid-group are ignored.
REQ-008 en=0 mid-group SHALL pause the group: counter and accumulator hold, no output.
REQ-009 A last beat at cycle t SHALL give out_en=1 for exactly the cycle after edge t+2, with out valid in that cycle.
REQ-010 Back-to-back groups SHALL run without bubbles; a first beat directly after a last beat starts a fresh accumulation.
REQ-011 Output path: if shift>0 add 2^(shift-1), then arithmetic right shift by shift; saturate to [-2^(OUT_BIT-1), 2^(OUT_BIT-1)-1]; if relu_en, negative results become 0.
REQ-012 out SHALL hold its last value while out_en=0.
REQ-013 clear=1 SHALL zero the counter and accumulator and discard the stage-1 beat and any same-cycle en beat; the aborted group SHALL produce no out_en.
REQ-014 A clear in the same cycle as a pending output update (last beat already in stage 2) SHALL NOT suppress that output.

Reset
REQ-015 reset=0 SHALL asynchronously set out=0, out_en=0, counter=0, accumulator=0, pipeline tags invalid, captured config=0.
REQ-016 After reset deassertion, the first en beat SHALL be a first beat; a group interrupted by reset SHALL produce no output.

Verification
REQ-017 Defaults, in all 1, weight all 2, bias 0, step 0, shift 0, one beat -> out=18, out_en single pulse 2 cycles later.
REQ-018 in all 255, weight all 127, shift 0 -> out=127 (saturated); weight all -128 -> out=-128; same with relu_en=1 -> out=0.
REQ-019 step=2, three beats each dot 10, bias 5, with en=0 gap cycles between them -> one out_en pulse, out=35, none earlier.
REQ-020 Same group with shift=2 -> out=9 (35+2=37, >>2); group total -35, shift=2 -> out=-9.
REQ-021 Continuous en, step=0, alternating dot values 3 and -4 -> out_en high every cycle, outputs 3,-4,3,... with no bubble.
REQ-022 clear on beat 2 of a step=3 group, reset low mid-group on another -> no out_en for either; next group from its first beat gives its correct sum.
